// File: rtl/serial_pkg.sv
// Shared types and mod-3 arithmetic for the serial word transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // (rem + bit*w) mod 3 with rem, w in 0..2
  function automatic logic [1:0] mod3_step(input logic [1:0] rem, input logic b,
                                           input logic [1:0] w);
    logic [2:0] s;
    s = {1'b0, rem} + (b ? {1'b0, w} : 3'd0);
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

endpackage

// File: rtl/mod3_tracker.sv
// Running remainder mod 3 of the bit stream sent so far, in either bit order.
module mod3_tracker
  import serial_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x_bit,
  input  logic       bit_valid,
  input  logic       clear,
  output logic [1:0] rem_n,
  output logic       mul3
);

  logic [1:0] rem_q;
  logic [1:0] w_q;
  logic [1:0] rem_x2;

  always_comb begin
    // 2*rem mod 3 is rem stepped by itself
    rem_x2 = mod3_step(rem_q, 1'b1, rem_q);
    if (MSB_FIRST) begin
      rem_n = mod3_step(rem_x2, x_bit, 2'd1);
    end else begin
      rem_n = mod3_step(rem_q, x_bit, w_q);
    end
    mul3 = bit_valid & (rem_n == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rem_q <= 2'd0;
      w_q   <= 2'd1;
    end else if (bit_valid) begin
      rem_q <= rem_n;
      w_q   <= (w_q == 2'd1) ? 2'd2 : 2'd1;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter with a running mod-3 reference output.
// Handshake: a word is taken at a posedge where load_valid & load_ready;
// load_ready is high only in IDLE and the word is not queued otherwise.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last,
  output logic             mul3,
  output logic             done,
  output logic [1:0]       final_rem,
  output state_t           state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic [GW-1:0]    gap_q;
  logic             done_q;
  logic [1:0]       final_q;
  logic             take;
  logic             bit_last;
  logic [1:0]       rem_n;
  logic             mul3_w;

  assign take     = load_valid & load_ready;
  assign bit_last = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (take) state_n = SHIFT;
      SHIFT:   if (bit_last) state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_q == GW'(GAP_LAST)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == IDLE);
    x_valid    = (state_q == SHIFT);
    last       = bit_last;
    x          = x_valid & (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
    mul3       = mul3_w;
    done       = done_q;
    final_rem  = final_q;
    state_dbg  = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      final_q <= 2'd0;
    end else begin
      if (take) begin
        sr_q  <= load_data;
        cnt_q <= '0;
      end else if (x_valid) begin
        sr_q  <= MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
        cnt_q <= bit_last ? '0 : cnt_q + 1'b1;
      end
      if (bit_last) begin
        gap_q <= '0;
      end else if (state_q == GAP) begin
        gap_q <= gap_q + 1'b1;
      end
      done_q <= bit_last;
      if (bit_last) begin
        final_q <= rem_n;
      end
    end
  end

  mod3_tracker #(
    .MSB_FIRST(MSB_FIRST)
  ) u_mod3 (
    .clk      (clk),
    .reset    (reset),
    .x_bit    (x),
    .bit_valid(x_valid),
    .clear    (take),
    .rem_n    (rem_n),
    .mul3     (mul3_w)
  );

endmodule

// File: tb/tb_serial_word_tx.sv
// Bench for serial_word_tx: MSB-first/GAP=2 and LSB-first/GAP=0 instances against a prefix-value model.
module tb_serial_word_tx;
  import serial_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst[2];
  logic         lv[2];
  logic [W-1:0] ld[2];
  logic         lr[2], xo[2], xv[2], lst[2], m3[2], dn[2];
  logic [1:0]   fr[2];
  state_t       sd[2];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit started = 1'b0;
  logic prev_last[2];
  int last_hs[2];
  // item: [5] done marker, [4] x, [3] mul3, [2] last, [1:0] remainder
  logic [5:0] q0[$];
  logic [5:0] q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_word_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u0 (
    .clk(clk), .reset(rst[0]), .load_valid(lv[0]), .load_data(ld[0]),
    .load_ready(lr[0]), .x(xo[0]), .x_valid(xv[0]), .last(lst[0]), .mul3(m3[0]),
    .done(dn[0]), .final_rem(fr[0]), .state_dbg(sd[0])
  );

  serial_word_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u1 (
    .clk(clk), .reset(rst[1]), .load_valid(lv[1]), .load_data(ld[1]),
    .load_ready(lr[1]), .x(xo[1]), .x_valid(xv[1]), .last(lst[1]), .mul3(m3[1]),
    .done(dn[1]), .final_rem(fr[1]), .state_dbg(sd[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected stream from the integer value of the bits sent so far.
  task automatic push_model(input int d, input logic [W-1:0] data);
    int unsigned val;
    logic b;
    logic [5:0] it;
    val = 0;
    for (int i = 0; i < W; i++) begin
      b = (d == 0) ? data[W-1-i] : data[i];
      if (d == 0) val = val * 2 + b;
      else        val = val + (int'(b) << i);
      it = {1'b0, b, ((val % 3) == 0), (i == W - 1), 2'(val % 3)};
      if (d == 0) q0.push_back(it); else q1.push_back(it);
    end
    it = {1'b1, 3'b000, 2'(val % 3)};
    if (d == 0) q0.push_back(it); else q1.push_back(it);
  endtask

  task automatic send(input int d, input logic [W-1:0] data, input bit hold, input int spacing);
    int t;
    t = 0;
    lv[d] = 1'b1;
    ld[d] = data;
    while (lr[d] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("load_accept_in_time", (t < 200), 1);
    if (t >= 200) begin
      lv[d] = 1'b0;
      return;
    end
    if (spacing > 0) check("frame_spacing", cyc - last_hs[d], spacing);
    last_hs[d] = cyc;
    push_model(d, data);
    @(negedge clk);
    if (!hold) lv[d] = 1'b0;
    check("first_bit_latency", xv[d], 1);
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    while ((((d == 0) ? q0.size() : q1.size()) != 0 || lr[d] !== 1'b1) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", (t < 300), 1);
  endtask

  always @(negedge clk) begin : monitor
    logic [5:0] it;
    int sz;
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        check("done_timing", dn[d], prev_last[d]);
        if (xv[d]) begin
          check("ready_low_in_shift", lr[d], 0);
          sz = (d == 0) ? q0.size() : q1.size();
          if (sz == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_bit: dut %0d x=%0b with no word pending", d, xo[d]);
          end else begin
            it = (d == 0) ? q0.pop_front() : q1.pop_front();
            check("bit_kind", it[5], 0);
            check("x", xo[d], it[4]);
            check("mul3", m3[d], it[3]);
            check("last", lst[d], it[2]);
          end
        end else begin
          check("idle_outputs", {xo[d], m3[d], lst[d]}, 0);
        end
        if (dn[d]) begin
          sz = (d == 0) ? q0.size() : q1.size();
          if (sz == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: dut %0d final_rem=%0d", d, fr[d]);
          end else begin
            it = (d == 0) ? q0.pop_front() : q1.pop_front();
            check("done_kind", it[5], 1);
            check("final_rem", fr[d], it[1:0]);
          end
        end
        prev_last[d] <= lst[d] & xv[d];
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      lv[d] = 1'b0;
      ld[d] = '0;
      prev_last[d] = 1'b0;
      last_hs[d] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_load_ready", lr[d], 1);
      check("rst_outputs", {xo[d], xv[d], lst[d], m3[d], dn[d]}, 0);
      check("rst_final_rem", fr[d], 0);
      check("rst_state", sd[d], IDLE);
      rst[d] = 1'b0;
    end
    started = 1'b1;

    // Directed words with known results
    send(0, 16'hAD4D, 0, 0); wait_idle(0); check("final_rem_ad4d", fr[0], 1);
    send(0, 16'hFFFF, 0, 0); wait_idle(0); check("final_rem_ffff", fr[0], 0);
    send(0, 16'h0000, 0, 0); wait_idle(0); check("final_rem_0000", fr[0], 0);
    send(1, 16'h0003, 0, 0); wait_idle(1); check("final_rem_lsb_0003", fr[1], 0);

    // Random words on both instances
    for (int i = 0; i < 12; i++) begin
      send(i % 2, W'($urandom), 0, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(0);
    wait_idle(1);

    // Reset on the 7th bit of a frame
    send(0, 16'hAD4D, 0, 0); wait_idle(0); check("final_rem_before_reset", fr[0], 1);
    send(0, W'($urandom), 0, 0);
    repeat (6) @(negedge clk);
    #1;
    rst[0] = 1'b1;
    q0.delete();
    @(negedge clk);
    check("midreset_x_valid", xv[0], 0);
    check("midreset_load_ready", lr[0], 1);
    check("midreset_final_rem", fr[0], 0);
    check("midreset_done", dn[0], 0);
    rst[0] = 1'b0;
    send(0, W'($urandom), 0, 0); wait_idle(0);

    // load_valid held high: GAP=2 spacing, then GAP=0 back-to-back
    send(0, W'($urandom), 1, 0);
    send(0, W'($urandom), 1, 19);
    send(0, W'($urandom), 0, 19);
    wait_idle(0);
    send(1, W'($urandom), 1, 0);
    send(1, 16'h0003, 1, 17);
    send(1, W'($urandom), 0, 17);
    wait_idle(1);

    repeat (3) @(negedge clk);
    check("queues_empty", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
